// File: rtl/lcd_ctrl.sv
// HD44780 4-bit sequencer: power-on init, then endless two-line refresh of the
// players' clocks as "P1 MM:SS" / "P2 MM:SS".
`timescale 1ns/1ps
module lcd_ctrl #(
    parameter int T_POR  = 2000000,
    parameter int T_INIT = 410000,
    parameter int T_EN   = 50,
    parameter int T_CMD  = 4000,
    parameter int T_CLR  = 160000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] min1,
    input  logic [5:0] seg1,
    input  logic [5:0] min2,
    input  logic [5:0] seg2,
    output logic [5:0] lcd,
    output logic       ready,
    output logic       frame_done
);
    typedef enum logic [2:0] {S_POR, S_WAKE, S_FUNC4, S_CMD, S_FRAME} state_t;
    typedef enum logic [1:0] {PH_SETUP, PH_ENABLE, PH_HOLD, PH_WAIT} phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [23:0] cnt_q, cnt_d;
    logic [4:0]  idx_q, idx_d;
    logic        nib_lo_q, nib_lo_d;
    logic [5:0]  m1_q, m1_d, s1_q, s1_d, m2_q, m2_d, s2_q, s2_d;
    logic [5:0]  lcd_q, lcd_d;
    logic        ready_q, ready_d;
    logic        frame_done_q, frame_done_d;

    logic [23:0] len;
    logic        done;
    logic [7:0]  cur_byte;
    logic        cur_rs;

    function automatic logic [7:0] digit_char(input logic [5:0] v, input logic units);
        logic [5:0] c;
        c = (v > 6'd59) ? 6'd59 : v;
        return units ? (8'h30 + {2'b00, c % 6'd10}) : (8'h30 + {2'b00, c / 6'd10});
    endfunction

    // Byte (or single nibble, in the high half) currently on the bus.
    always_comb begin
        cur_byte = 8'h00;
        cur_rs   = 1'b0;
        case (state_q)
            S_WAKE:  cur_byte = 8'h30;
            S_FUNC4: cur_byte = 8'h20;
            S_CMD: begin
                case (idx_q[1:0])
                    2'd0:    cur_byte = 8'h28;
                    2'd1:    cur_byte = 8'h0C;
                    2'd2:    cur_byte = 8'h06;
                    default: cur_byte = 8'h01;
                endcase
            end
            S_FRAME: begin
                cur_rs = (idx_q != 5'd0) && (idx_q != 5'd9);
                case (idx_q)
                    5'd0:         cur_byte = 8'h80;
                    5'd1, 5'd10:  cur_byte = 8'h50;
                    5'd2:         cur_byte = 8'h31;
                    5'd11:        cur_byte = 8'h32;
                    5'd3, 5'd12:  cur_byte = 8'h20;
                    5'd4:         cur_byte = digit_char(m1_q, 1'b0);
                    5'd5:         cur_byte = digit_char(m1_q, 1'b1);
                    5'd6, 5'd15:  cur_byte = 8'h3A;
                    5'd7:         cur_byte = digit_char(s1_q, 1'b0);
                    5'd8:         cur_byte = digit_char(s1_q, 1'b1);
                    5'd9:         cur_byte = 8'hC0;
                    5'd13:        cur_byte = digit_char(m2_q, 1'b0);
                    5'd14:        cur_byte = digit_char(m2_q, 1'b1);
                    5'd16:        cur_byte = digit_char(s2_q, 1'b0);
                    5'd17:        cur_byte = digit_char(s2_q, 1'b1);
                    default:      cur_byte = 8'h20;
                endcase
            end
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        nib_lo_d     = nib_lo_q;
        cnt_d        = cnt_q + 24'd1;
        m1_d         = m1_q;
        s1_d         = s1_q;
        m2_d         = m2_q;
        s2_d         = s2_q;
        frame_done_d = 1'b0;

        len = 24'(T_EN);
        if (state_q == S_POR) begin
            len = 24'(T_POR);
        end else if (phase_q == PH_WAIT) begin
            case (state_q)
                S_WAKE:  len = 24'(T_INIT);
                S_CMD:   len = (idx_q == 5'd3) ? 24'(T_CLR) : 24'(T_CMD);
                default: len = 24'(T_CMD);
            endcase
        end
        done = (cnt_q == len - 24'd1);

        if (done) begin
            cnt_d = 24'd0;
            if (state_q == S_POR) begin
                state_d  = S_WAKE;
                phase_d  = PH_SETUP;
                idx_d    = 5'd0;
                nib_lo_d = 1'b0;
            end else begin
                case (phase_q)
                    PH_SETUP:  phase_d = PH_ENABLE;
                    PH_ENABLE: phase_d = PH_HOLD;
                    PH_HOLD: begin
                        // Full bytes go straight on to their low nibble.
                        if ((state_q == S_CMD || state_q == S_FRAME) && !nib_lo_q) begin
                            phase_d  = PH_SETUP;
                            nib_lo_d = 1'b1;
                        end else begin
                            phase_d = PH_WAIT;
                        end
                    end
                    default: begin
                        phase_d  = PH_SETUP;
                        nib_lo_d = 1'b0;
                        idx_d    = idx_q + 5'd1;
                        case (state_q)
                            S_WAKE: if (idx_q == 5'd2) begin
                                state_d = S_FUNC4;
                                idx_d   = 5'd0;
                            end
                            S_FUNC4: begin
                                state_d = S_CMD;
                                idx_d   = 5'd0;
                            end
                            S_CMD: if (idx_q == 5'd3) begin
                                state_d = S_FRAME;
                                idx_d   = 5'd0;
                            end
                            default: if (idx_q == 5'd17) begin
                                idx_d        = 5'd0;
                                frame_done_d = 1'b1;
                            end
                        endcase
                        // Latch the players' times as a new frame begins.
                        if (idx_d == 5'd0 && state_d == S_FRAME) begin
                            m1_d = min1;
                            s1_d = seg1;
                            m2_d = min2;
                            s2_d = seg2;
                        end
                    end
                endcase
            end
        end

        if (state_q == S_POR)
            lcd_d = 6'b000000;
        else
            lcd_d = {cur_rs, phase_q == PH_ENABLE, nib_lo_q ? cur_byte[3:0] : cur_byte[7:4]};
        ready_d = (state_q == S_FRAME);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_POR;
            phase_q      <= PH_SETUP;
            cnt_q        <= 24'd0;
            idx_q        <= 5'd0;
            nib_lo_q     <= 1'b0;
            m1_q         <= 6'd0;
            s1_q         <= 6'd0;
            m2_q         <= 6'd0;
            s2_q         <= 6'd0;
            lcd_q        <= 6'd0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            nib_lo_q     <= nib_lo_d;
            m1_q         <= m1_d;
            s1_q         <= s1_d;
            m2_q         <= m2_d;
            s2_q         <= s2_d;
            lcd_q        <= lcd_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign lcd        = lcd_q;
    assign ready      = ready_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: nibble stream, timing and snapshot behaviour
// compared against a byte-level model of the display traffic.
`timescale 1ns/1ps
module tb_lcd_ctrl;
    localparam int T_POR    = 20;
    localparam int T_INIT   = 10;
    localparam int T_EN     = 2;
    localparam int T_CMD    = 5;
    localparam int T_CLR    = 8;
    localparam int BYTE_P   = 6*T_EN + T_CMD;
    localparam int FRAME_P  = 18*BYTE_P;
    localparam int INIT_LEN = T_POR + 3*(3*T_EN + T_INIT) + (3*T_EN + T_CMD)
                            + 3*(6*T_EN + T_CMD) + 6*T_EN + T_CLR;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] min1 = 6'd0, seg1 = 6'd0, min2 = 6'd0, seg2 = 6'd0;
    logic [5:0] lcd;
    logic       ready, frame_done;

    lcd_ctrl #(
        .T_POR(T_POR), .T_INIT(T_INIT), .T_EN(T_EN), .T_CMD(T_CMD), .T_CLR(T_CLR)
    ) dut (
        .clk(clk), .rst(rst),
        .min1(min1), .seg1(seg1), .min2(min2), .seg2(seg2),
        .lcd(lcd), .ready(ready), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Player values in force for each frame: {min1, seg1, min2, seg2}.
    int frame_vals[0:7][0:3];
    int init_nib[0:11] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 6, 0, 1};

    function automatic int clamp59(input int v);
        return (v > 59) ? 59 : v;
    endfunction

    function automatic int frame_byte(input int f, input int b);
        int p, k;
        p = (b < 9) ? 0 : 1;
        k = b % 9;
        case (k)
            0: return p ? 'hC0 : 'h80;
            1: return 'h50;
            2: return p ? 'h32 : 'h31;
            3: return 'h20;
            4: return 'h30 + clamp59(frame_vals[f][2*p]) / 10;
            5: return 'h30 + clamp59(frame_vals[f][2*p]) % 10;
            6: return 'h3A;
            7: return 'h30 + clamp59(frame_vals[f][2*p+1]) / 10;
            default: return 'h30 + clamp59(frame_vals[f][2*p+1]) % 10;
        endcase
    endfunction

    // Expected {RS, D} of the n-th nibble strobed since reset release.
    function automatic int exp_nibble(input int n);
        int m, f, b, by, d, rs;
        if (n < 12) return init_nib[n];
        m  = n - 12;
        f  = m / 36;
        b  = (m % 36) / 2;
        by = frame_byte(f, b);
        d  = (m % 2 == 0) ? (by >> 4) : (by & 15);
        rs = (b % 9 != 0) ? 1 : 0;
        return rs*16 + d;
    endfunction

    task automatic apply_frame(input int f);
        min1 = 6'(frame_vals[f][0]);
        seg1 = 6'(frame_vals[f][1]);
        min2 = 6'(frame_vals[f][2]);
        seg2 = 6'(frame_vals[f][3]);
    endtask

    task automatic run_pass(input int pass);
        int cyc, nib, fd_n, off, f, rel;
        logic e, prev_e, prev_ready, first_e, found;
        rst = 1'b1;
        if (pass == 0) begin
            frame_vals[0] = '{5, 7, 59, 0};
        end else begin
            for (int i = 0; i < 4; i++) frame_vals[0][i] = int'($urandom_range(0, 63));
        end
        apply_frame(0);
        repeat (3) @(negedge clk);
        check_eq("rst_lcd", int'(lcd), 0);
        check_eq("rst_ready", int'(ready), 0);
        check_eq("rst_frame_done", int'(frame_done), 0);
        #1 rst = 1'b0;

        cyc = 0; nib = 0; fd_n = 0;
        prev_e = 1'b0; prev_ready = 1'b0; first_e = 1'b0;
        off = (pass == 0) ? int'($urandom_range(20, 120)) : int'($urandom_range(20, FRAME_P - 20));
        while (cyc < INIT_LEN + 2*FRAME_P + FRAME_P/2) begin
            @(negedge clk);
            cyc++;
            e = lcd[4];
            if (cyc <= T_POR + T_EN) check_eq("e_low_por", int'(e), 0);
            if (e && !prev_e && !first_e) begin
                first_e = 1'b1;
                check_eq("first_e_cyc", cyc, T_POR + T_EN + 1);
                check_eq("first_nib", int'({lcd[5], lcd[3:0]}), 3);
            end
            if (!e && prev_e) begin
                check_eq($sformatf("nib%0d", nib), int'({lcd[5], lcd[3:0]}), exp_nibble(nib));
                nib++;
            end
            if (ready != prev_ready)
                check_eq("ready_edge_cyc", cyc, ready ? INIT_LEN + 1 : -1);
            if (frame_done) begin
                fd_n++;
                check_eq("frame_done_cyc", cyc, INIT_LEN + fd_n*FRAME_P);
            end
            // Mid-frame input change, taking effect from the next frame.
            if (cyc > INIT_LEN) begin
                rel = cyc - INIT_LEN - 1;
                f   = rel / FRAME_P;
                if (rel % FRAME_P == off && f < 7) begin
                    for (int i = 0; i < 4; i++) frame_vals[f+1][i] = int'($urandom_range(0, 63));
                    if (pass == 0 && f == 0) begin
                        frame_vals[1][0] = 63;
                        frame_vals[1][1] = 8;
                        frame_vals[1][3] = 60;
                    end
                    apply_frame(f + 1);
                end
            end
            prev_e     = e;
            prev_ready = ready;
        end
        check_eq("ready_final", int'(ready), 1);
        check_eq("frames_done", fd_n, 2);
        check_eq("nib_count_min", int'(nib >= 12 + 72), 1);

        if (pass == 0) begin
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                @(negedge clk);
                if (lcd[4]) found = 1'b1;
            end
            check_eq("enable_found", int'(found), 1);
            #1 rst = 1'b1;
            #1;
            check_eq("async_rst_lcd", int'(lcd), 0);
            check_eq("async_rst_ready", int'(ready), 0);
            check_eq("async_rst_frame_done", int'(frame_done), 0);
        end
    endtask

    initial begin
        run_pass(0);
        run_pass(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_ctrl.md
# lcd_ctrl

Sequencer for the chess timer's character LCD (HD44780-compatible, 4-bit bus, R/W tied low on the board). It runs the power-on initialisation and then continuously refreshes both lines with the two players' times: "P1 MM:SS" on line 1 and "P2 MM:SS" on line 2. The time inputs come from the two player counters, and `lcd` drives the Nexys 4 Pmod pins directly.

## Interface
- `T_POR`, default 2000000: cycles to wait after reset before the first nibble (20 ms at 100 MHz).
- `T_INIT`, default 410000: wait after each of the three 0x3 wake-up nibbles (4.1 ms).
- `T_EN`, default 50: length of each nibble phase (setup, E high, hold).
- `T_CMD`, default 4000: wait after each complete byte (40 us).
- `T_CLR`, default 160000: wait after the clear command 0x01 (1.6 ms).
- All parameters are ≥1 and <2^24.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `min1`, `seg1`, `min2`, `seg2`  in  6 each: player minutes and seconds, binary.
- `lcd`  out  6: {RS, E, D7, D6, D5, D4}.
- `ready`  out  1: high once initialisation has completed; stays high until reset.
- `frame_done`  out  1: one-cycle pulse when the last character of line 2 completes its `T_CMD` wait.

## Operation
- Nibble write, in three phases of `T_EN` cycles each:
  - SETUP: RS and D valid, E=0.
  - ENABLE: E=1, RS and D unchanged.
  - HOLD: E=0, RS and D unchanged.
- Byte write: high nibble first, then low nibble immediately, then a wait of `T_CMD` cycles (`T_CLR` for 0x01). RS, E and D hold their last values during the wait.
- FSM states: POR, WAKE, FUNC4, CMD, FRAME.
  - POR: wait `T_POR` cycles.
  - WAKE: nibble 0x3 (RS=0) three times, each followed by `T_INIT` cycles.
  - FUNC4: nibble 0x2 (RS=0), followed by `T_CMD` cycles.
  - CMD: bytes 0x28, 0x0C, 0x06, 0x01, all RS=0. `ready` goes high in the cycle FRAME is entered.
  - FRAME: 18-byte refresh sequence, repeated forever:
    - 0x80 (RS=0), then "P1 " and m1 tens, m1 units, ':', s1 tens, s1 units (RS=1);
    - 0xC0 (RS=0), then "P2 " and the same five characters for player 2 (RS=1).
    - Consecutive frames follow with no gap.
- Snapshot: `min1`, `seg1`, `min2`, `seg2` are registered in the first cycle of each frame, i.e. the SETUP of the 0x80 high nibble. Input changes during a frame appear only in the next frame.
- Conversion: values above 59 are clamped to 59.
  - tens = v/10, units = v%10, each in 0..5 / 0..9.
  - Character = 0x30 + digit. ':' = 0x3A, 'P' = 0x50, '1' = 0x31, '2' = 0x32, space = 0x20.
- Reset asserted at any point, including mid-nibble:
  - `lcd` = 6'b000000, `ready` = 0, `frame_done` = 0 immediately.
  - After release, the sequence restarts at POR.

## Timing
- Reset values: `lcd` = 0, `ready` = 0, `frame_done` = 0. All outputs are registered.
- First E rising edge: `T_POR + T_EN` cycles after the first clock edge with `rst` low.
- Byte period: 6·`T_EN` + `T_CMD` cycles. Clear: 6·`T_EN` + `T_CLR`.
- Init length: `T_POR` + 3·(3·`T_EN` + `T_INIT`) + (3·`T_EN` + `T_CMD`) + 3·(6·`T_EN` + `T_CMD`) + 6·`T_EN` + `T_CLR`.
- Frame length: exactly 18·(6·`T_EN` + `T_CMD`) cycles.
- `frame_done` period equals the frame length.
- Wait counters are 24 bits and terminal-count exact (a wait of N means N cycles), with no off-by-one between phases.

## Test plan
Benches use `T_POR`=20, `T_INIT`=10, `T_EN`=2, `T_CMD`=5, `T_CLR`=8.
- Reset: `rst` high → `lcd`=0, `ready`=0. Release → E stays 0 for 20 cycles, then the first nibble shows D=0x3, RS=0.
- Init: capture nibbles on E falling edges → 3,3,3,2,2,8,0,C,0,6,0,1 (RS=0 throughout). `ready` rises at FRAME entry at the computed init cycle.
- Frame content: `min1`=5, `seg1`=7, `min2`=59, `seg2`=0 → decoded line 1 "P1 05:07", line 2 "P2 59:00". Frame length 18·17=306 cycles between `frame_done` pulses.
- Clamp: `min1`=63, `seg2`=60 → displayed "59" for both fields.
- Snapshot: change `seg1` 7→8 mid-frame → current frame shows "07", the next frame shows "08".
- Reset mid-operation: assert `rst` during an ENABLE phase of frame 2 → `lcd`=0 in the same cycle with no clock edge needed. After release, the full init sequence is repeated.
